// File: rtl/ps2_scan_parser.sv
// ---------------------------------------------------------------------------
// ps2_scan_parser
//
// Purpose:
//   Folds PS/2 scan-code prefix bytes (E0 = extended, F0 = break) into single
//   key events. Drops non-key bytes (BAT result, ack, resend, error codes).
//   Queues the decoded events in a small first-word-fall-through FIFO. The
//   consumer drains that FIFO with a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   i_rst_n      asynchronous active-low reset
//   i_byte_en    one-cycle strobe: i_byte carries a newly received byte
//   i_byte       received scan-code byte
//   o_valid      FIFO head holds an event
//   i_ready      consumer accepts the head event this cycle
//   o_code       head event key code with prefixes stripped
//   o_ext        head event was E0-prefixed
//   o_brk        head event is a release (1) or a make (0)
//   o_overflow   sticky: an event was dropped because the FIFO was full
//   o_proto_err  sticky: an illegal prefix sequence was seen
//   o_count      current FIFO occupancy, 0..DEPTH
//
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//   When defined, a make event that repeats the most recent make (same
//   ext/code, with no matching break in between) is suppressed. This removes
//   typematic auto-repeat.
// ---------------------------------------------------------------------------
module ps2_scan_parser #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_byte_en,
    input  logic [7:0]    i_byte,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [7:0]    o_code,
    output logic          o_ext,
    output logic          o_brk,
    output logic          o_overflow,
    output logic          o_proto_err,
    output logic [AW:0]   o_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          byteFiltered;
    logic          emitReq;
    logic          emitExt;
    logic          emitBrk;
    logic          protoErrSet;
    logic          pushReq;
    logic          push;
    logic          pop;
    logic          full;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          protoErr_q;
    logic [9:0]    headEntry;

    // Byte values that never represent keys and are silently discarded.
    always_comb begin
        byteFiltered = 1'b0;
        case (i_byte)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: byteFiltered = 1'b1;
            default:                                   byteFiltered = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        emitReq     = 1'b0;
        emitExt     = 1'b0;
        emitBrk     = 1'b0;
        protoErrSet = 1'b0;
        if (i_byte_en) begin
            case (state_q)
                IDLE: begin
                    if (i_byte == 8'hE0)      state_d = EXT;
                    else if (i_byte == 8'hF0) state_d = BRK;
                    else if (!byteFiltered)   emitReq = 1'b1;
                end
                EXT: begin
                    if (i_byte == 8'hF0)      state_d = EXTBRK;
                    else if (i_byte == 8'hE0) state_d = EXT;
                    else begin
                        state_d = IDLE;
                        emitReq = !byteFiltered;
                        emitExt = 1'b1;
                    end
                end
                BRK, EXTBRK: begin
                    state_d = IDLE;
                    // After F0, a further prefix of either kind is illegal.
                    if (i_byte == 8'hE0 || i_byte == 8'hF0) begin
                        protoErrSet = 1'b1;
                    end else begin
                        emitReq = !byteFiltered;
                        emitExt = (state_q == EXTBRK);
                        emitBrk = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       lastValid_q;
    logic       lastExt_q;
    logic [7:0] lastCode_q;
    logic       lastMatch;

    assign lastMatch = lastValid_q && (lastExt_q == emitExt) && (lastCode_q == i_byte);
    assign pushReq   = emitReq && !(!emitBrk && lastMatch);

    // The register follows every non-repeat make, even when the FIFO drops it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lastValid_q <= 1'b0;
            lastExt_q   <= 1'b0;
            lastCode_q  <= 8'h00;
        end else if (emitReq) begin
            if (!emitBrk && !lastMatch) begin
                lastValid_q <= 1'b1;
                lastExt_q   <= emitExt;
                lastCode_q  <= i_byte;
            end else if (emitBrk && lastMatch) begin
                lastValid_q <= 1'b0;
            end
        end
    end
`else
    assign pushReq = emitReq;
`endif

    // A pop in the same cycle frees a slot, so a push into a full FIFO with a
    // simultaneous pop is still accepted.
    assign full = (count_q == (AW+1)'(DEPTH));
    assign pop  = (count_q != '0) && i_ready;
    assign push = pushReq && (!full || pop);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            protoErr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= {emitExt, emitBrk, i_byte};
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (pop) rdPtr_q <= rdPtr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (pushReq && !push) overflow_q <= 1'b1;
            if (protoErrSet)      protoErr_q <= 1'b1;
        end
    end

    assign headEntry   = mem_q[rdPtr_q];
    assign o_valid     = (count_q != '0);
    assign o_code      = headEntry[7:0];
    assign o_brk       = headEntry[8];
    assign o_ext       = headEntry[9];
    assign o_overflow  = overflow_q;
    assign o_proto_err = protoErr_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_ps2_scan_parser.sv
// ---------------------------------------------------------------------------
// tb_ps2_scan_parser
//
// Purpose:
//   Directed self-checking bench for ps2_scan_parser with DEPTH=4.
//   Drives inputs on the falling clock edge and samples outputs on the
//   falling edge as well, half a cycle away from the active rising edge.
//   The typematic expectations follow PS2_TYPEMATIC_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_ps2_scan_parser;

    logic       clk;
    logic       i_rst_n;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_code;
    logic       o_ext;
    logic       o_brk;
    logic       o_overflow;
    logic       o_proto_err;
    logic [2:0] o_count;

    int checks = 0;
    int errors = 0;

    ps2_scan_parser #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_code      (o_code),
        .o_ext       (o_ext),
        .o_brk       (o_brk),
        .o_overflow  (o_overflow),
        .o_proto_err (o_proto_err),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one byte for one cycle. On return we are at the falling edge
    // one cycle after the strobe, where any resulting event must be visible.
    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        i_byte_en = 1'b1;
        i_byte    = b;
        @(negedge clk);
        i_byte_en = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n   = 1'b0;
        i_byte_en = 1'b0;
        i_byte    = 8'h00;
        i_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_code got %h want 00", o_code); end
        checks++; if ({o_ext, o_brk} !== 2'b00) begin errors++; $display("[TB] FAIL reset_extbrk got %b want 00", {o_ext, o_brk}); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", o_overflow); end
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got %b want 0", o_proto_err); end
        checks++; if (o_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", o_count); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_make_break();
        i_ready = 1'b1;
        sendByte(8'h1C);
        checks++; if ({o_valid, o_ext, o_brk, o_code} !== {3'b100, 8'h1C}) begin errors++; $display("[TB] FAIL make_1c got v%b e%b b%b %h want v1 e0 b0 1c", o_valid, o_ext, o_brk, o_code); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL make_1c_popped got %b want 0", o_valid); end
        sendByte(8'hF0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL f0_no_event got %b want 0", o_valid); end
        sendByte(8'h1C);
        checks++; if ({o_valid, o_ext, o_brk, o_code} !== {3'b101, 8'h1C}) begin errors++; $display("[TB] FAIL break_1c got v%b e%b b%b %h want v1 e0 b1 1c", o_valid, o_ext, o_brk, o_code); end
        @(negedge clk);
    endtask

    task automatic test_extended();
        i_ready = 1'b1;
        sendByte(8'hE0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL e0_no_event got %b want 0", o_valid); end
        sendByte(8'h75);
        checks++; if ({o_valid, o_ext, o_brk, o_code} !== {3'b110, 8'h75}) begin errors++; $display("[TB] FAIL ext_make_75 got v%b e%b b%b %h want v1 e1 b0 75", o_valid, o_ext, o_brk, o_code); end
        sendByte(8'hE0);
        sendByte(8'hF0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL e0f0_no_event got %b want 0", o_valid); end
        sendByte(8'h75);
        checks++; if ({o_valid, o_ext, o_brk, o_code} !== {3'b111, 8'h75}) begin errors++; $display("[TB] FAIL ext_break_75 got v%b e%b b%b %h want v1 e1 b1 75", o_valid, o_ext, o_brk, o_code); end
        @(negedge clk);
    endtask

    task automatic test_filter_proto();
        i_ready = 1'b1;
        sendByte(8'hAA);
        sendByte(8'hFA);
        checks++; if ({o_valid, o_count} !== 4'b0000) begin errors++; $display("[TB] FAIL filtered_bytes got v%b cnt%0d want v0 cnt0", o_valid, o_count); end
        sendByte(8'hF0);
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("[TB] FAIL proto_before got %b want 0", o_proto_err); end
        sendByte(8'hE0);
        checks++; if ({o_proto_err, o_valid} !== 2'b10) begin errors++; $display("[TB] FAIL proto_f0e0 got err%b v%b want err1 v0", o_proto_err, o_valid); end
        sendByte(8'h23);
        checks++; if ({o_valid, o_ext, o_brk, o_code} !== {3'b100, 8'h23}) begin errors++; $display("[TB] FAIL after_proto_23 got v%b e%b b%b %h want v1 e0 b0 23", o_valid, o_ext, o_brk, o_code); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) sendByte(codes[i]);
        checks++; if ({o_count, o_overflow} !== {3'd4, 1'b0}) begin errors++; $display("[TB] FAIL fill_4 got cnt%0d ovf%b want cnt4 ovf0", o_count, o_overflow); end
        sendByte(codes[4]);
        checks++; if ({o_count, o_overflow} !== {3'd4, 1'b1}) begin errors++; $display("[TB] FAIL overflow got cnt%0d ovf%b want cnt4 ovf1", o_count, o_overflow); end
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({o_valid, o_code} !== {1'b1, codes[i]}) begin errors++; $display("[TB] FAIL drain_%0d got v%b %h want v1 %h", i, o_valid, o_code, codes[i]); end
            @(negedge clk);
        end
        checks++; if ({o_valid, o_count} !== 4'b0000) begin errors++; $display("[TB] FAIL drained_empty got v%b cnt%0d want v0 cnt0", o_valid, o_count); end
        i_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        // A pending E0 prefix must not survive reset.
        sendByte(8'hE0);
        applyReset();
        checks++; if ({o_overflow, o_proto_err, o_count} !== 5'b00000) begin errors++; $display("[TB] FAIL rereset got ovf%b err%b cnt%0d want 0 0 0", o_overflow, o_proto_err, o_count); end
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) sendByte(codes[i]);
        checks++; if ({o_ext, o_code} !== {1'b0, 8'h16}) begin errors++; $display("[TB] FAIL prefix_discarded got e%b %h want e0 16", o_ext, o_code); end
        // Push and pop together while full.
        @(negedge clk);
        i_byte_en = 1'b1;
        i_byte    = codes[4];
        i_ready   = 1'b1;
        @(negedge clk);
        i_byte_en = 1'b0;
        i_ready   = 1'b0;
        checks++; if ({o_count, o_overflow} !== {3'd4, 1'b0}) begin errors++; $display("[TB] FAIL full_push_pop got cnt%0d ovf%b want cnt4 ovf0", o_count, o_overflow); end
        i_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if ({o_valid, o_code} !== {1'b1, codes[i]}) begin errors++; $display("[TB] FAIL b2b_drain_%0d got v%b %h want v1 %h", i, o_valid, o_code, codes[i]); end
            @(negedge clk);
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty got %b want 0", o_valid); end
    endtask

    task automatic test_typematic();
        logic [7:0] bytes    [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        logic       expBrk   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PS2_TYPEMATIC_FILTER_EN
        logic       expValid [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic       expValid [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        applyReset();
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sendByte(bytes[i]);
            checks++; if (o_valid !== expValid[i]) begin errors++; $display("[TB] FAIL typematic_valid_%0d got %b want %b", i, o_valid, expValid[i]); end
            if (expValid[i]) begin
                checks++; if ({o_ext, o_brk, o_code} !== {1'b0, expBrk[i], 8'h1C}) begin errors++; $display("[TB] FAIL typematic_event_%0d got e%b b%b %h want e0 b%b 1c", i, o_ext, o_brk, o_code, expBrk[i]); end
            end
        end
        @(negedge clk);
        checks++; if ({o_overflow, o_count} !== 4'b0000) begin errors++; $display("[TB] FAIL typematic_end got ovf%b cnt%0d want 0 0", o_overflow, o_count); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_filter_proto();
        test_overflow();
        test_back_to_back();
        test_typematic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
